// File: rtl/i2c_pkg.sv
// i2c_pkg: shared states, codec constants and majority helper for the I2C codec responder.
package i2c_pkg;
  localparam logic [6:0] CODEC_DEV_ADDR = 7'h1A;
  localparam logic [6:0] CODEC_RESET_REG = 7'h0F;
  localparam int WORD_BITS = 16;
  localparam int NUM_REGS = 16;
  localparam logic [7:0] WR_ADDR_BYTE = {CODEC_DEV_ADDR, 1'b0};
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_BYTE1, S_ACK_1, S_BYTE2, S_ACK_2, S_WAIT_STOP
  } state_e;
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction
endpackage

// File: rtl/i2c_line_cond.sv
// i2c_line_cond: SCL/SDA synchronizer, optional majority filter (I2C_RSP_GLITCH_FILTER_EN),
// and SCL edge / START / STOP detection against the previous conditioned sample.
module i2c_line_cond
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic sda_o,
  output logic start_o,
  output logic stop_o
);
  logic [1:0] scl_s_q, sda_s_q;
  logic scl, sda, scl_p_q, sda_p_q;
`ifdef I2C_RSP_GLITCH_FILTER_EN
  logic [1:0] scl_h_q, sda_h_q;
  logic scl_f_q, sda_f_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      scl_h_q <= 2'b11;
      sda_h_q <= 2'b11;
      scl_f_q <= 1'b1;
      sda_f_q <= 1'b1;
    end else begin
      scl_h_q <= {scl_h_q[0], scl_s_q[1]};
      sda_h_q <= {sda_h_q[0], sda_s_q[1]};
      scl_f_q <= maj3({scl_h_q, scl_s_q[1]});
      sda_f_q <= maj3({sda_h_q, sda_s_q[1]});
    end
  assign scl = scl_f_q;
  assign sda = sda_f_q;
`else
  assign scl = scl_s_q[1];
  assign sda = sda_s_q[1];
`endif
  // Idle bus is high; resetting to 1 avoids phantom edges after reset.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      scl_s_q <= 2'b11;
      sda_s_q <= 2'b11;
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_s_q <= {scl_s_q[0], scl_i};
      sda_s_q <= {sda_s_q[0], sda_i};
      scl_p_q <= scl;
      sda_p_q <= sda;
    end
  assign scl_rise_o = scl & ~scl_p_q;
  assign scl_fall_o = ~scl & scl_p_q;
  assign sda_o = sda;
  assign start_o = scl & scl_p_q & sda_p_q & ~sda;
  assign stop_o = scl & scl_p_q & ~sda_p_q & sda;
endmodule

// File: rtl/i2c_codec_responder.sv
// i2c_codec_responder: write-only I2C codec control-port model with local register file.
// Optional SCL/SDA glitch filter via I2C_RSP_GLITCH_FILTER_EN.
module i2c_codec_responder
  import i2c_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic       reg_wr_o,
  output logic [6:0] reg_addr_o,
  output logic [8:0] reg_data_o,
  input  logic [3:0] rd_addr_i,
  output logic [8:0] rd_data_o,
  output logic       busy_o,
  output logic [7:0] frame_count_o
);
  logic scl_rise, scl_fall, sda, start, stop, commit;
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, b1_q, b1_d, frame_cnt_q;
  logic reg_wr_q;
  logic [6:0] reg_addr_q, c_addr;
  logic [8:0] reg_data_q, c_data;
  logic [8:0] rf_q [NUM_REGS];
  i2c_line_cond u_line (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .sda_o      (sda),
    .start_o    (start),
    .stop_o     (stop)
  );
  assign c_addr = b1_q[7:1];
  assign c_data = {b1_q[0], sh_q};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    b1_d = b1_q;
    commit = 1'b0;
    if (stop) state_d = S_IDLE;
    else if (start) begin
      state_d = S_ADDR;
      cnt_d = '0;
    end else
      case (state_q)
        S_ADDR, S_BYTE1, S_BYTE2:
          if (scl_rise && cnt_q < 4'd8) begin
            sh_d = {sh_q[6:0], sda};
            cnt_d = cnt_q + 4'd1;
            // A foreign address drops off the bus before any ACK slot.
            if (state_q == S_ADDR && cnt_q == 4'd7 && sh_d != WR_ADDR_BYTE) state_d = S_IDLE;
          end else if (scl_fall && cnt_q == 4'd8) begin
            state_d = state_e'(state_q + 3'd1);
            b1_d = state_q == S_BYTE1 ? sh_q : b1_q;
          end
        S_ACK_A, S_ACK_1, S_ACK_2:
          if (scl_fall) begin
            state_d = state_e'(state_q + 3'd1);
            cnt_d = '0;
            commit = state_q == S_ACK_2;
          end
        default: ;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      b1_q <= '0;
      reg_wr_q <= 1'b0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      frame_cnt_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      b1_q <= b1_d;
      reg_wr_q <= commit;
      if (commit) begin
        reg_addr_q <= c_addr;
        reg_data_q <= c_data;
        frame_cnt_q <= frame_cnt_q + 8'd1;
        if (c_addr == CODEC_RESET_REG)
          for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        else if (c_addr < 7'(NUM_REGS))
          rf_q[c_addr[3:0]] <= c_data;
      end
    end
  // ACK is driven for exactly the ACK states, so a reset releases SDA at once.
  assign sda_oe_o = state_q == S_ACK_A || state_q == S_ACK_1 || state_q == S_ACK_2;
  assign busy_o = state_q != S_IDLE;
  assign reg_wr_o = reg_wr_q;
  assign reg_addr_o = reg_addr_q;
  assign reg_data_o = reg_data_q;
  assign frame_count_o = frame_cnt_q;
  assign rd_data_o = rf_q[rd_addr_i];
endmodule

// File: tb/tb_i2c_codec_responder.sv
// tb_i2c_codec_responder: directed bus-master stimulus with hand-computed expectations.
module tb_i2c_codec_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic [3:0] rd_addr = '0;
  logic sda_oe, reg_wr, busy;
  logic [6:0] reg_addr;
  logic [8:0] reg_data, rd_data;
  logic [7:0] frame_count;
  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;
  int wr_base;
  logic a0, a1, a2, a3;
  logic [15:0] words [10] = '{16'h001A, 16'h0217, 16'h0479, 16'h0600, 16'h0812,
                              16'h0B67, 16'h0C00, 16'h0E4A, 16'h1000, 16'h1201};

  i2c_codec_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .scl_i         (scl_m),
    .sda_i         (sda_m & ~sda_oe),
    .sda_oe_o      (sda_oe),
    .reg_wr_o      (reg_wr),
    .reg_addr_o    (reg_addr),
    .reg_data_o    (reg_data),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (rd_data),
    .busy_o        (busy),
    .frame_count_o (frame_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (reg_wr === 1'b1) wr_cnt++;

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_c();
    sda_m = 1'b1; wclk(4);
    scl_m = 1'b1; wclk(4);
    sda_m = 1'b0; wclk(4);
    scl_m = 1'b0; wclk(4);
  endtask

  task automatic stop_c();
    sda_m = 1'b0; wclk(4);
    scl_m = 1'b1; wclk(4);
    sda_m = 1'b1; wclk(8);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wclk(4);
      scl_m = 1'b1; wclk(8);
      scl_m = 1'b0; wclk(4);
    end
  endtask

  task automatic ack_slot(output logic a);
    sda_m = 1'b1; wclk(4);
    scl_m = 1'b1; wclk(4);
    a = sda_oe;
    wclk(4);
    scl_m = 1'b0; wclk(4);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    send_bits(b);
    ack_slot(a);
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       output logic k0, output logic k1, output logic k2);
    start_c();
    send_byte(b0, k0);
    send_byte(b1, k1);
    send_byte(b2, k2);
    stop_c();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_sda_oe"}, 32'(sda_oe), 0);
    chk({tag, "_reg_wr"}, 32'(reg_wr), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_reg_addr"}, 32'(reg_addr), 0);
    chk({tag, "_reg_data"}, 32'(reg_data), 0);
    chk({tag, "_frame_count"}, 32'(frame_count), 0);
    chk({tag, "_rd_data"}, 32'(rd_data), 0);
  endtask

  initial begin
    wclk(3);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    wclk(10);

    wr_base = wr_cnt;
    start_c();
    chk("busy_after_start", 32'(busy), 1);
    send_byte(8'h34, a0);
    send_byte(8'h00, a1);
    send_byte(8'h1A, a2);
    chk("f1_wr_before_stop", 32'(wr_cnt - wr_base), 1);
    stop_c();
    chk("f1_ack_addr", 32'(a0), 1);
    chk("f1_ack_b1", 32'(a1), 1);
    chk("f1_ack_b2", 32'(a2), 1);
    chk("f1_busy_after_stop", 32'(busy), 0);
    chk("f1_sda_released", 32'(sda_oe), 0);
    chk("f1_reg_wr_pulse_done", 32'(reg_wr), 0);
    chk("f1_reg_addr", 32'(reg_addr), 32'h00);
    chk("f1_reg_data", 32'(reg_data), 32'h01A);
    rd_addr = 4'd0; #1;
    chk("f1_rd0", 32'(rd_data), 32'h01A);
    chk("f1_frame_count", 32'(frame_count), 1);

    wr_base = wr_cnt;
    start_c();
    send_byte(8'h36, a0);
    chk("f2_busy_dropped", 32'(busy), 0);
    send_byte(8'h00, a1);
    send_byte(8'h1A, a2);
    stop_c();
    chk("f2_no_ack_addr", 32'(a0), 0);
    chk("f2_no_ack_b1", 32'(a1), 0);
    chk("f2_no_ack_b2", 32'(a2), 0);
    chk("f2_no_wr", 32'(wr_cnt - wr_base), 0);
    chk("f2_frame_count", 32'(frame_count), 1);

    rst_n = 1'b0; wclk(2);
    rst_n = 1'b1; wclk(10);
    wr_base = wr_cnt;
    a3 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      frame(8'h34, words[i][15:8], words[i][7:0], a0, a1, a2);
      a3 = a3 & a0 & a1 & a2;
    end
    chk("load_all_acked", 32'(a3), 1);
    chk("load_wr_count", 32'(wr_cnt - wr_base), 10);
    chk("load_frame_count", 32'(frame_count), 10);
    rd_addr = 4'd9; #1; chk("load_rd9", 32'(rd_data), 32'h001);
    rd_addr = 4'd4; #1; chk("load_rd4", 32'(rd_data), 32'h012);
    rd_addr = 4'd7; #1; chk("load_rd7", 32'(rd_data), 32'h04A);
    rd_addr = 4'd5; #1; chk("load_rd5", 32'(rd_data), 32'h167);
    rd_addr = 4'd0; #1; chk("load_rd0", 32'(rd_data), 32'h01A);
    chk("load_last_addr", 32'(reg_addr), 32'h09);

    wr_base = wr_cnt;
    frame(8'h34, 8'h1E, 8'h00, a0, a1, a2);
    chk("clr_acks", 32'({a0, a1, a2}), 32'h7);
    chk("clr_wr_once", 32'(wr_cnt - wr_base), 1);
    chk("clr_reg_addr", 32'(reg_addr), 32'h0F);
    chk("clr_frame_count", 32'(frame_count), 11);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); #1;
      chk($sformatf("clr_rd%0d", i), 32'(rd_data), 0);
    end

    wr_base = wr_cnt;
    start_c();
    send_byte(8'h34, a0);
    send_byte(8'h04, a1);
    stop_c();
    chk("early_stop_no_wr", 32'(wr_cnt - wr_base), 0);
    chk("early_stop_idle", 32'(busy), 0);
    start_c();
    send_byte(8'h34, a0);
    send_byte(8'h04, a1);
    frame(8'h34, 8'h04, 8'h7B, a0, a1, a2);
    chk("rstart_one_wr", 32'(wr_cnt - wr_base), 1);
    rd_addr = 4'd2; #1;
    chk("rstart_rd2", 32'(rd_data), 32'h07B);
    chk("rstart_frame_count", 32'(frame_count), 12);

    start_c();
    send_byte(8'h34, a0);
    send_bits(8'h06);
    sda_m = 1'b1; wclk(4);
    chk("mid_ack1_driven", 32'(sda_oe), 1);
    #3 rst_n = 1'b0;
    #1;
    check_zero_outputs("mid_ack_reset");
    wclk(2);
    rst_n = 1'b1;
    scl_m = 1'b1; sda_m = 1'b1;
    wclk(10);
    wr_base = wr_cnt;
    frame(8'h34, 8'h06, 8'h55, a0, a1, a2);
    chk("post_reset_acks", 32'({a0, a1, a2}), 32'h7);
    chk("post_reset_wr", 32'(wr_cnt - wr_base), 1);
    rd_addr = 4'd3; #1;
    chk("post_reset_rd3", 32'(rd_data), 32'h055);
    chk("post_reset_frame_count", 32'(frame_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
